aurora_rx_lane_deskew: RTL and testbench

Parametrised receive-side lane combiner that replaces fixed 4-lane bit concatenation with per-lane deskew buffering. It sits between the Aurora RX lane outputs and the FireSim channel logic. Each lane's data is buffered in a small FIFO. Alignment markers realign all enabled lanes to a common word boundary. The block then emits one merged word per cycle and checks marker alignment continuously while running.

---
 rtl/aurora_rx_lane_deskew.sv | 125 ++++++++++++
 tb/tb_aurora_rx_lane_deskew.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aurora_rx_lane_deskew.sv
// Receive-side lane combiner: per-lane deskew FIFOs realigned on a marker word,
// merged into one word per cycle with continuous marker alignment checking.
module aurora_rx_lane_deskew #(
  parameter int          LANES  = 4,
  parameter int          LANE_W = 64,
  parameter int          DEPTH  = 8,
  parameter logic [63:0] MARKER = 64'hA5A5_5A5A_C3C3_3C3C
) (
  input  logic                    user_clk,
  input  logic                    reset,
  input  logic [LANES*LANE_W-1:0] rx_data,
  input  logic [LANES-1:0]        rx_valid,
  input  logic [LANES-1:0]        lane_en,
  input  logic                    clear_err,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic                    out_valid,
  output logic                    aligned,
  output logic                    skew_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [LANE_W-1:0] MK = LANE_W'(MARKER);

  typedef enum logic [1:0] {FLUSH, HUNT, ALIGNED} state_t;
  state_t state, state_nxt;

  logic [LANES-1:0]        en_r;
  logic [LANES-1:0]        seen;
  logic [AW:0]             wr_ptr [LANES];
  logic [AW:0]             rd_ptr [LANES];
  logic [LANE_W:0]         mem    [LANES][DEPTH];

  logic [LANES-1:0]        hit, wr, wr_ok, full, empty, tag_rd, tag_in, ovf;
  logic [LANES*LANE_W-1:0] merged_p0, data_p1;
  logic                    vld_p1;
  logic                    pop, any1, all1, mixed, data_pop, err, en_chg, all_seen, load;

  always_comb begin
    hit       = '0;
    wr        = '0;
    full      = '0;
    empty     = '0;
    tag_rd    = '0;
    tag_in    = '0;
    merged_p0 = '0;
    for (int i = 0; i < LANES; i++) begin
      hit[i]    = en_r[i] && rx_valid[i] && (rx_data[i*LANE_W +: LANE_W] == MK);
      empty[i]  = (wr_ptr[i] == rd_ptr[i]);
      full[i]   = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                  (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
      tag_rd[i] = mem[i][rd_ptr[i][AW-1:0]][LANE_W];
      // Before a lane's first marker its words are discarded, the marker included.
      wr[i]     = en_r[i] && rx_valid[i] &&
                  ((state == ALIGNED) || ((state == HUNT) && seen[i]));
      tag_in[i] = hit[i] && (state == ALIGNED);
      if (en_r[i]) merged_p0[i*LANE_W +: LANE_W] = mem[i][rd_ptr[i][AW-1:0]][LANE_W-1:0];
    end
    pop      = (state == ALIGNED) && (en_r != '0) && ((~empty & en_r) == en_r);
    any1     = |(tag_rd & en_r);
    all1     = ((tag_rd & en_r) == en_r);
    mixed    = pop && any1 && !all1;
    data_pop = pop && !any1;
    // A full FIFO still accepts a write when it pops in the same cycle.
    ovf      = wr & full & ~{LANES{pop}};
    wr_ok    = wr & ~ovf;
    err      = (|ovf) || mixed;
    en_chg   = (lane_en != en_r);
    all_seen = (en_r != '0) && (((seen | hit) & en_r) == en_r);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FLUSH:   state_nxt = HUNT;
      HUNT:    if (err || en_chg) state_nxt = FLUSH;
               else if (all_seen) state_nxt = ALIGNED;
      ALIGNED: if (err || en_chg) state_nxt = FLUSH;
      default: state_nxt = FLUSH;
    endcase
  end

  assign load = data_pop && (state_nxt == ALIGNED);

  always_ff @(posedge user_clk) begin
    if (reset) begin
      state    <= HUNT;
      en_r     <= lane_en;
      seen     <= '0;
      skew_err <= 1'b0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      for (int i = 0; i < LANES; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      state  <= state_nxt;
      en_r   <= lane_en;
      vld_p1 <= load;
      if (load) data_p1 <= merged_p0;
      if (err) skew_err <= 1'b1;
      else if (clear_err) skew_err <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        if (state == FLUSH) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          seen[i]   <= 1'b0;
        end else begin
          if ((state == HUNT) && hit[i] && !seen[i]) seen[i] <= 1'b1;
          if (wr_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
          if (pop && en_r[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge user_clk) begin
    for (int i = 0; i < LANES; i++)
      if (wr_ok[i]) mem[i][wr_ptr[i][AW-1:0]] <= {tag_in[i], rx_data[i*LANE_W +: LANE_W]};
  end

  // p1: registered merged word
  assign out_data  = data_p1;
  assign out_valid = vld_p1;
  assign aligned   = (state == ALIGNED);
endmodule

// File: tb/tb_aurora_rx_lane_deskew.sv
// Bench for aurora_rx_lane_deskew: queue-based lane model compared every cycle,
// plus hand-computed timing/value expectations per scenario.
module tb_aurora_rx_lane_deskew;
  localparam int          LANES = 4;
  localparam int          DEPTH = 8;
  localparam logic [63:0] MK    = 64'hA5A5_5A5A_C3C3_3C3C;
  localparam int          M_FLUSH = 0, M_HUNT = 1, M_AL = 2;
  localparam int          HN = 4096;

  logic           clk = 1'b0;
  logic           reset;
  logic [255:0]   rx_data;
  logic [3:0]     rx_valid, lane_en;
  logic           clear_err;
  logic [255:0]   out_data;
  logic           out_valid, aligned, skew_err;

  aurora_rx_lane_deskew #(.LANES(LANES), .LANE_W(64), .DEPTH(DEPTH), .MARKER(MK)) dut (
    .user_clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .lane_en(lane_en), .clear_err(clear_err), .out_data(out_data),
    .out_valid(out_valid), .aligned(aligned), .skew_err(skew_err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, gcyc = 0;
  bit model_ok = 0;

  // model state
  logic [64:0] q [LANES][$];
  int          m_mode;
  logic [3:0]  m_seen, m_en;
  logic        e_valid, e_aligned, e_err;
  logic [255:0] e_data;

  logic        h_v [HN];
  logic        h_al[HN];
  logic        h_er[HN];
  logic [63:0] h_d0[HN];
  logic [63:0] h_d3[HN];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, gcyc, act, exp);
    end
  endtask

  task automatic model_step();
    int nxt;
    bit err, dpop, pop, any1, all1;
    logic [255:0] md;
    logic [63:0] w;
    if (reset) begin
      for (int i = 0; i < LANES; i++) q[i].delete();
      m_seen = '0; m_en = lane_en; m_mode = M_HUNT;
      e_valid = 0; e_data = '0; e_err = 0; e_aligned = 0; model_ok = 1;
      return;
    end
    nxt = m_mode; err = 0; dpop = 0; md = '0;
    if (m_mode == M_FLUSH) begin
      for (int i = 0; i < LANES; i++) q[i].delete();
      m_seen = '0; nxt = M_HUNT;
    end else begin
      pop = (m_mode == M_AL) && (m_en != 0);
      for (int i = 0; i < LANES; i++) if (m_en[i] && q[i].size() == 0) pop = 0;
      if (pop) begin
        any1 = 0; all1 = 1;
        for (int i = 0; i < LANES; i++) if (m_en[i]) begin
          if (q[i][0][64]) any1 = 1; else all1 = 0;
          md[i*64 +: 64] = q[i][0][63:0];
          void'(q[i].pop_front());
        end
        if (any1 && !all1) err = 1;
        else if (!any1) dpop = 1;
      end
      for (int i = 0; i < LANES; i++) if (m_en[i] && rx_valid[i]) begin
        w = rx_data[i*64 +: 64];
        if (m_mode == M_HUNT && !m_seen[i]) begin
          if (w == MK) m_seen[i] = 1'b1;
        end else if (q[i].size() < DEPTH) begin
          q[i].push_back({(m_mode == M_AL) && (w == MK), w});
        end else err = 1;
      end
      if (m_mode == M_HUNT && m_en != 0 && (m_seen & m_en) == m_en) nxt = M_AL;
      if (err || lane_en != m_en) nxt = M_FLUSH;
    end
    e_valid = dpop && (nxt == M_AL);
    if (e_valid) e_data = md;
    if (err) e_err = 1; else if (clear_err) e_err = 0;
    m_en = lane_en; m_mode = nxt; e_aligned = (m_mode == M_AL);
  endtask

  initial forever begin
    @(posedge clk);
    gcyc++;
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (gcyc < HN) begin
      h_v[gcyc] = out_valid; h_al[gcyc] = aligned; h_er[gcyc] = skew_err;
      h_d0[gcyc] = out_data[63:0]; h_d3[gcyc] = out_data[255:192];
    end
    if (model_ok) begin
      chk("out_valid", 256'(out_valid), 256'(e_valid));
      chk("aligned",   256'(aligned),   256'(e_aligned));
      chk("skew_err",  256'(skew_err),  256'(e_err));
      if (e_valid) chk("out_data", out_data, e_data);
    end
  end

  // Lane word at lane-local position p: p=0 marker, then 0x100+k data with a
  // marker after every 'per' data words; 'late' lane swaps its first periodic marker.
  task automatic lane_word(input int lane, input int p, input int per, input int late,
                           output logic v, output logic [63:0] d);
    int idx;
    v = (p >= 0); d = '0;
    if (p < 0) return;
    if (p == 0) begin d = MK; return; end
    idx = p - 1;
    if (per > 0 && lane == late && idx == per) idx = per + 1;
    else if (per > 0 && lane == late && idx == per + 1) idx = per;
    if (per > 0 && (idx % (per + 1)) == per) d = MK;
    else d = 64'h100 + 64'(per > 0 ? idx - idx / (per + 1) : idx);
  endtask

  task automatic idle(input int n);
    rx_valid = '0; rx_data = '0; clear_err = 0; reset = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    lane_en = 4'b1111; reset = 1; rx_valid = '0;
    @(posedge clk); #1;
    reset = 0;
    idle(2);
  endtask

  task automatic stream(input int s0, input int s1, input int s2, input int s3,
                        input int n, input int per, input int late, input int en_t,
                        input int rst_t, output int t0);
    int sk[4];
    logic v; logic [63:0] d;
    sk = '{s0, s1, s2, s3};
    t0 = gcyc;
    for (int t = 0; t < n; t++) begin
      for (int i = 0; i < LANES; i++) begin
        lane_word(i, t - sk[i], per, late, v, d);
        rx_valid[i] = v; rx_data[i*64 +: 64] = d;
      end
      lane_en = (en_t >= 0 && t >= en_t) ? 4'b0111 : 4'b1111;
      reset = (t == rst_t);
      clear_err = 0;
      @(posedge clk); #1;
    end
    idle(4);
  endtask

  initial begin
    int T;
    reset = 1; lane_en = 4'b1111; rx_valid = '0; rx_data = '0; clear_err = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_aligned",   256'(aligned),   256'(0));
    chk("rst_skew_err",  256'(skew_err),  256'(0));
    chk("rst_out_data",  out_data,        256'(0));
    reset = 0;
    idle(9);

    // zero skew
    stream(0, 0, 0, 0, 30, 0, -1, -1, -1, T);
    chk("z_al_T",    256'(h_al[T]),   256'(0));
    chk("z_al_T1",   256'(h_al[T+1]), 256'(1));
    chk("z_v_T2",    256'(h_v[T+2]),  256'(0));
    chk("z_v_T3",    256'(h_v[T+3]),  256'(1));
    chk("z_d0_T3",   256'(h_d0[T+3]), 256'(64'h100));
    chk("z_d3_T3",   256'(h_d3[T+3]), 256'(64'h100));
    chk("z_d0_T4",   256'(h_d0[T+4]), 256'(64'h101));
    chk("z_v_T28",   256'(h_v[T+28]), 256'(1));

    // skew 0/1/3/5
    do_reset();
    stream(0, 1, 3, 5, 30, 0, -1, -1, -1, T);
    chk("sk_v_T7",   256'(h_v[T+7]),  256'(0));
    chk("sk_v_T8",   256'(h_v[T+8]),  256'(1));
    chk("sk_d0_T8",  256'(h_d0[T+8]), 256'(64'h100));
    chk("sk_d3_T8",  256'(h_d3[T+8]), 256'(64'h100));
    chk("sk_err",    256'(h_er[T+25]), 256'(0));

    // periodic marker every 16 words
    do_reset();
    stream(0, 0, 0, 0, 45, 16, -1, -1, -1, T);
    chk("pm_d0_T18", 256'(h_d0[T+18]), 256'(64'h10F));
    chk("pm_v_T19",  256'(h_v[T+19]),  256'(0));
    chk("pm_v_T20",  256'(h_v[T+20]),  256'(1));
    chk("pm_d0_T20", 256'(h_d0[T+20]), 256'(64'h110));
    chk("pm_err",    256'(h_er[T+40]), 256'(0));

    // lane 2 marker one word late
    do_reset();
    stream(0, 0, 0, 0, 40, 8, 2, -1, -1, T);
    chk("late_v_T10",  256'(h_v[T+10]),  256'(1));
    chk("late_d_T10",  256'(h_d0[T+10]), 256'(64'h107));
    chk("late_al_T10", 256'(h_al[T+10]), 256'(1));
    chk("late_er_T10", 256'(h_er[T+10]), 256'(0));
    chk("late_er_T11", 256'(h_er[T+11]), 256'(1));
    chk("late_al_T11", 256'(h_al[T+11]), 256'(0));
    chk("late_al_T19", 256'(h_al[T+19]), 256'(1));
    chk("late_d_T21",  256'(h_d0[T+21]), 256'(64'h110));
    chk("late_err_hold", 256'(skew_err), 256'(1));
    clear_err = 1;
    @(posedge clk); #1;
    clear_err = 0;
    chk("clear_err", 256'(skew_err), 256'(0));
    idle(2);

    // skew of 8 words overflows
    do_reset();
    stream(0, 0, 0, 8, 30, 0, -1, -1, -1, T);
    chk("ov_al_T9",  256'(h_al[T+9]),  256'(1));
    chk("ov_er_T9",  256'(h_er[T+9]),  256'(0));
    chk("ov_er_T10", 256'(h_er[T+10]), 256'(1));
    chk("ov_al_T10", 256'(h_al[T+10]), 256'(0));

    // lane 3 disabled while aligned
    do_reset();
    stream(0, 0, 0, 0, 30, 8, -1, 5, -1, T);
    chk("en_al_T5",  256'(h_al[T+5]),  256'(1));
    chk("en_al_T6",  256'(h_al[T+6]),  256'(0));
    chk("en_er_T6",  256'(h_er[T+6]),  256'(0));
    chk("en_al_T10", 256'(h_al[T+10]), 256'(1));
    chk("en_v_T12",  256'(h_v[T+12]),  256'(1));
    chk("en_d0_T12", 256'(h_d0[T+12]), 256'(64'h108));
    chk("en_d3_T12", 256'(h_d3[T+12]), 256'(0));

    // reset mid-stream
    do_reset();
    stream(0, 0, 0, 0, 20, 0, -1, -1, 8, T);
    chk("mr_v_T8",   256'(h_v[T+8]),   256'(1));
    chk("mr_d0_T8",  256'(h_d0[T+8]),  256'(64'h105));
    chk("mr_v_T9",   256'(h_v[T+9]),   256'(0));
    chk("mr_al_T9",  256'(h_al[T+9]),  256'(0));
    chk("mr_er_T9",  256'(h_er[T+9]),  256'(0));
    chk("mr_d0_T9",  256'(h_d0[T+9]),  256'(0));
    chk("mr_d3_T9",  256'(h_d3[T+9]),  256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
